reg_bank_serializer: RTL and testbench

- Read-side companion to the parallel register bank: takes one K-bit word from the bank's Q output and shifts it out one bit per accepted transfer.
- Uses a valid/ready load handshake on the parallel side and a valid/ready/last handshake on the serial side.
- Sits between a pipeline register stage and any bit-serial consumer, such as a debug/UART path or a serial datapath.

---
 rtl/reg_bank_serializer.sv | 83 ++++++++
 tb/tb_reg_bank_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_serializer.sv
// Parallel-to-serial converter: accepts one K-bit word over a valid/ready load
// handshake and emits it one bit per accepted serial transfer.
module reg_bank_serializer #(
  parameter int K         = 28,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [K-1:0] D,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last,
  output logic         busy
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [K-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           at_last;

  assign at_last = (cnt_q == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = D;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            // Move the next bit toward the output end, zero-filling behind it.
            shreg_d = MSB_FIRST ? {shreg_q[K-2:0], 1'b0} : {1'b0, shreg_q[K-1:1]};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == SHIFT);
    ser_valid  = busy;
    ser_last   = busy && at_last;
    ser_out    = busy && (MSB_FIRST ? shreg_q[K-1] : shreg_q[0]);
    // Reset gates load_ready directly so no word is offered as accepted during reset.
    load_ready = (state_q == IDLE) && Reset;
  end

endmodule

// File: tb/tb_reg_bank_serializer.sv
// Self-checking bench: LSB-first and MSB-first instances driven in lockstep and
// compared every cycle against a word/bit-index reference model.
module tb_reg_bank_serializer;
  localparam int K = 28;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic [K-1:0] D = '0;
  logic         load_valid = 1'b0;
  logic         ser_ready = 1'b0;

  logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;
  logic m_load_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  bit           mdl_known = 1'b0;
  bit           mdl_busy  = 1'b0;
  logic [K-1:0] mdl_word  = '0;
  int           mdl_idx   = 0;
  int           acc_bits  = 0;

  always #5 CLK = ~CLK;

  reg_bank_serializer #(.K(K), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .Reset(Reset), .D(D), .load_valid(load_valid),
    .load_ready(l_load_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .ser_ready(ser_ready), .ser_last(l_ser_last), .busy(l_busy)
  );

  reg_bank_serializer #(.K(K), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .Reset(Reset), .D(D), .load_valid(load_valid),
    .load_ready(m_load_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .ser_ready(ser_ready), .ser_last(m_ser_last), .busy(m_busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle: compare outputs mid-cycle, advance the model with the
  // inputs the DUT will see at the coming edge, then move past that edge.
  task automatic step();
    logic exp_lr;
    @(negedge CLK);
    exp_lr = Reset && !mdl_busy;
    chk("load_ready_lsb", l_load_ready, exp_lr);
    chk("load_ready_msb", m_load_ready, exp_lr);
    if (mdl_known) begin
      chk("busy_lsb", l_busy, mdl_busy);
      chk("busy_msb", m_busy_o, mdl_busy);
      chk("ser_valid_lsb", l_ser_valid, mdl_busy);
      chk("ser_valid_msb", m_ser_valid, mdl_busy);
      chk("ser_last_lsb", l_ser_last, mdl_busy && (mdl_idx == K-1));
      chk("ser_last_msb", m_ser_last, mdl_busy && (mdl_idx == K-1));
      if (mdl_busy) begin
        chk("ser_out_lsb", l_ser_out, mdl_word[mdl_idx]);
        chk("ser_out_msb", m_ser_out, mdl_word[K-1-mdl_idx]);
      end
    end
    if (Reset && l_ser_valid === 1'b1 && ser_ready) begin
      acc_bits++;
      if (l_ser_last === 1'b1) begin
        chk("word_len", acc_bits, K);
        acc_bits = 0;
      end
    end
    if (!Reset) begin
      mdl_known = 1'b1;
      mdl_busy  = 1'b0;
      mdl_idx   = 0;
      acc_bits  = 0;
    end else if (!mdl_busy) begin
      if (load_valid) begin
        mdl_word = D;
        mdl_idx  = 0;
        mdl_busy = 1'b1;
      end
    end else if (ser_ready) begin
      if (mdl_idx == K-1) mdl_busy = 1'b0;
      else mdl_idx++;
    end
    @(posedge CLK);
    #1;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic drain(input int mode);
    int i;
    i = 0;
    while (mdl_busy && i < 8*K) begin
      case (mode)
        0:       ser_ready = 1'b1;
        1:       ser_ready = ((i % 3) == 0);
        default: ser_ready = $urandom_range(0, 1);
      endcase
      step();
      i++;
    end
    chk("drain_done", l_busy, 1'b0);
  endtask

  task automatic load_word(input logic [K-1:0] d);
    D          = d;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    D          = K'($urandom);
  endtask

  initial begin
    // Reset for two cycles, then release.
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();

    // LSB-first word with continuous ready.
    ser_ready = 1'b1;
    load_word(28'h0A5F3C1);
    drain(0);
    step();

    // Backpressure pattern.
    load_word(28'h0000003);
    drain(1);
    step();

    // Single-ended pattern, most visible on the MSB-first instance.
    ser_ready = 1'b1;
    load_word(28'h8000001);
    drain(0);
    step();

    // Load pulse mid-word is ignored.
    load_word(28'h0000000);
    for (int i = 0; i < 5; i++) step();
    D = 28'hFFFFFFF;
    load_valid = 1'b1;
    step();
    step();
    load_valid = 1'b0;
    drain(0);
    step();
    step();

    // Load held through the end of a word is taken in the following IDLE cycle.
    load_word(28'h0000000);
    for (int i = 0; i < 5; i++) step();
    D = 28'hFFFFFFF;
    load_valid = 1'b1;
    for (int i = 0; i < K; i++) step();
    load_valid = 1'b0;
    drain(0);
    step();

    // Reset mid-word discards the partial word.
    load_word(28'hFFFFFFF);
    for (int i = 0; i < 10; i++) step();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    D = 'x;
    step();
    load_word(28'h0000001);
    drain(0);
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      D          = K'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      ser_ready  = ($urandom_range(0, 3) != 0);
      Reset      = ($urandom_range(0, 79) != 0);
      step();
    end
    Reset = 1'b1;
    load_valid = 1'b0;
    drain(2);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
